// File: rtl/controle_jogo_rodadas_pkg.sv
// rtl/controle_jogo_rodadas_pkg.sv - state encoding and default sizing for the game round controller
package controle_jogo_rodadas_pkg;

  localparam int TIMEOUT_CICLOS_PADRAO  = 3000;
  localparam int RODADAS_FACIL_PADRAO   = 8;
  localparam int RODADAS_DIFICIL_PADRAO = 16;

  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    PREPARACAO     = 4'd1,
    INICIA_RODADA  = 4'd2,
    ESPERA_JOGADA  = 4'd3,
    REGISTRA       = 4'd4,
    COMPARA        = 4'd5,
    PROXIMA_JOGADA = 4'd6,
    PROXIMA_RODADA = 4'd7,
    FIM_ACERTO     = 4'd8,
    FIM_ERRO       = 4'd9,
    FIM_TIMEOUT    = 4'd10
  } estado_t;

endpackage

// File: rtl/controle_jogo_rodadas_if.sv
// rtl/controle_jogo_rodadas_if.sv - control/status bundle between the round controller and the datapath
interface controle_jogo_rodadas_if;

  logic       jogada_feita;
  logic       igual;
  logic       fim_rodada;
  logic [3:0] limite;
  logic       zeraE;
  logic       contaE;
  logic       zeraL;
  logic       contaL;
  logic       zeraR;
  logic       registraR;

  modport master (
    output zeraE, contaE, zeraL, contaL, zeraR, registraR,
    input  jogada_feita, igual, fim_rodada, limite
  );

  modport slave (
    input  zeraE, contaE, zeraL, contaL, zeraR, registraR,
    output jogada_feita, igual, fim_rodada, limite
  );

endinterface

// File: rtl/controle_jogo_rodadas_contador_timeout.sv
// rtl/controle_jogo_rodadas_contador_timeout.sv - modulo-N counter with clear, enable and terminal-count pulse
module contador_timeout #(
  parameter int MODULO = 3000
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int W = (MODULO > 1) ? $clog2(MODULO) : 1;
  localparam logic [W-1:0] ULTIMO = W'(MODULO - 1);

  logic [W-1:0] valor;

  always_ff @(posedge clock) begin
    if (!reset || zera) begin
      valor <= '0;
    end else if (conta) begin
      valor <= (valor == ULTIMO) ? '0 : valor + 1'b1;
    end
  end

  // Pulse only on the enabled cycle that reaches the last count
  assign fim = conta && (valor == ULTIMO);

endmodule

// File: rtl/controle_jogo_rodadas.sv
// rtl/controle_jogo_rodadas.sv - Moore control unit for the memory-sequence game; CONTROLE_JOGO_TIMEOUT_EN enables the per-play timeout
module controle_jogo_rodadas
  import controle_jogo_rodadas_pkg::*;
#(
`ifdef CONTROLE_JOGO_TIMEOUT_EN
  parameter int TIMEOUT_CICLOS  = TIMEOUT_CICLOS_PADRAO,
`endif
  parameter int RODADAS_FACIL   = RODADAS_FACIL_PADRAO,
  parameter int RODADAS_DIFICIL = RODADAS_DIFICIL_PADRAO
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          iniciar,
  input  logic                          sel_nivel,
  controle_jogo_rodadas_if.master       dp,
  output logic                          pronto,
  output logic                          acertou,
  output logic                          errou,
  output logic                          timeout,
  output logic [3:0]                    db_estado
);

  localparam logic [3:0] ULTIMA_FACIL   = 4'(RODADAS_FACIL - 1);
  localparam logic [3:0] ULTIMA_DIFICIL = 4'(RODADAS_DIFICIL - 1);

  estado_t estado, proximo;
  logic    nivel_reg;
  logic    ultima;
  logic    fim_tempo;

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado    <= INICIAL;
      nivel_reg <= 1'b0;
    end else begin
      estado <= proximo;
      if (estado == PREPARACAO) nivel_reg <= sel_nivel;
    end
  end

  assign ultima = (dp.limite == (nivel_reg ? ULTIMA_DIFICIL : ULTIMA_FACIL));

`ifdef CONTROLE_JOGO_TIMEOUT_EN
  // Clearing outside ESPERA_JOGADA restarts the budget on every new play
  contador_timeout #(.MODULO(TIMEOUT_CICLOS)) u_contador_timeout (
    .clock (clock),
    .reset (reset),
    .zera  (estado != ESPERA_JOGADA),
    .conta (estado == ESPERA_JOGADA),
    .fim   (fim_tempo)
  );
`else
  assign fim_tempo = 1'b0;
`endif

  always_comb begin
    proximo = INICIAL;
    case (estado)
      INICIAL:        proximo = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:     proximo = INICIA_RODADA;
      INICIA_RODADA:  proximo = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        if (dp.jogada_feita)   proximo = REGISTRA;
        else if (fim_tempo)    proximo = FIM_TIMEOUT;
        else                   proximo = ESPERA_JOGADA;
      end
      REGISTRA:       proximo = COMPARA;
      COMPARA: begin
        if (!dp.igual)           proximo = FIM_ERRO;
        else if (!dp.fim_rodada) proximo = PROXIMA_JOGADA;
        else if (!ultima)        proximo = PROXIMA_RODADA;
        else                     proximo = FIM_ACERTO;
      end
      PROXIMA_JOGADA: proximo = ESPERA_JOGADA;
      PROXIMA_RODADA: proximo = INICIA_RODADA;
      FIM_ACERTO:     proximo = iniciar ? PREPARACAO : FIM_ACERTO;
      FIM_ERRO:       proximo = iniciar ? PREPARACAO : FIM_ERRO;
`ifdef CONTROLE_JOGO_TIMEOUT_EN
      FIM_TIMEOUT:    proximo = iniciar ? PREPARACAO : FIM_TIMEOUT;
`endif
      default:        proximo = INICIAL;
    endcase
  end

  always_comb begin
    dp.zeraE     = 1'b0;
    dp.contaE    = 1'b0;
    dp.zeraL     = 1'b0;
    dp.contaL    = 1'b0;
    dp.zeraR     = 1'b0;
    dp.registraR = 1'b0;
    pronto       = 1'b0;
    acertou      = 1'b0;
    errou        = 1'b0;
    timeout      = 1'b0;
    case (estado)
      PREPARACAO: begin
        dp.zeraE = 1'b1;
        dp.zeraL = 1'b1;
        dp.zeraR = 1'b1;
      end
      INICIA_RODADA:  dp.zeraE     = 1'b1;
      REGISTRA:       dp.registraR = 1'b1;
      PROXIMA_JOGADA: dp.contaE    = 1'b1;
      PROXIMA_RODADA: dp.contaL    = 1'b1;
      FIM_ACERTO: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      FIM_ERRO: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
`ifdef CONTROLE_JOGO_TIMEOUT_EN
      FIM_TIMEOUT: begin
        pronto  = 1'b1;
        timeout = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_controle_jogo_rodadas.sv
// tb/tb_controle_jogo_rodadas.sv - directed vector bench for controle_jogo_rodadas
module tb_controle_jogo_rodadas;

  localparam logic [9:0] O_NONE = 10'b0000000000;
  localparam logic [9:0] O_PREP = 10'b1010100000;
  localparam logic [9:0] O_INIR = 10'b1000000000;
  localparam logic [9:0] O_REG  = 10'b0000010000;
  localparam logic [9:0] O_PJ   = 10'b0100000000;
  localparam logic [9:0] O_PR   = 10'b0001000000;
  localparam logic [9:0] O_ACE  = 10'b0000001100;
  localparam logic [9:0] O_ERR  = 10'b0000001010;
  localparam logic [9:0] O_TMO  = 10'b0000001001;

  typedef struct {
    logic       rst;
    logic       ini;
    logic       sel;
    logic       jf;
    logic       ig;
    logic       fr;
    logic [3:0] lim;
    logic [3:0] est;
    logic [9:0] outs;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic       sel_nivel;
  logic       pronto, acertou, errou, timeout;
  logic [3:0] db_estado;
  int         vectors = 0;
  int         miscompares = 0;
  vec_t       tab[$];

  controle_jogo_rodadas_if dp ();

  controle_jogo_rodadas dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .sel_nivel (sel_nivel),
    .dp        (dp.master),
    .pronto    (pronto),
    .acertou   (acertou),
    .errou     (errou),
    .timeout   (timeout),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(input logic r, ini, sel, jf, ig, fr,
                              input logic [3:0] lim, est, input logic [9:0] outs);
    vec_t v;
    v.rst = r; v.ini = ini; v.sel = sel; v.jf = jf; v.ig = ig; v.fr = fr;
    v.lim = lim; v.est = est; v.outs = outs;
    return v;
  endfunction

  task automatic drive(input logic r, ini, sel, jf, ig, fr, input logic [3:0] lim);
    reset           = r;
    iniciar         = ini;
    sel_nivel       = sel;
    dp.jogada_feita = jf;
    dp.igual        = ig;
    dp.fim_rodada   = fr;
    dp.limite       = lim;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check(input string nome, input logic [3:0] est, input logic [9:0] outs);
    logic [9:0] got;
    got = {dp.zeraE, dp.contaE, dp.zeraL, dp.contaL, dp.zeraR, dp.registraR,
           pronto, acertou, errou, timeout};
    vectors++;
    if (db_estado !== est || got !== outs) begin
      miscompares++;
      $display("FAIL %s: estado=%0d outs=%b, required estado=%0d outs=%b",
               nome, db_estado, got, est, outs);
    end
  endtask

  initial begin
    // {rst, ini, sel, jf, ig, fr, lim, expected estado, expected outputs}
    tab.push_back(mk(0,0,0,0,0,0, 0,  0, O_NONE));
    tab.push_back(mk(1,0,0,0,0,0, 0,  0, O_NONE));
    tab.push_back(mk(1,1,0,0,0,0, 0,  1, O_PREP));
    tab.push_back(mk(1,0,0,0,0,0, 0,  2, O_INIR));
    tab.push_back(mk(1,0,0,0,0,0, 0,  3, O_NONE));
    tab.push_back(mk(1,0,0,0,0,0, 0,  3, O_NONE));
    tab.push_back(mk(1,0,0,1,0,0, 0,  4, O_REG));
    tab.push_back(mk(1,0,0,0,1,1, 0,  5, O_NONE));
    tab.push_back(mk(1,0,0,0,1,1, 0,  7, O_PR));
    tab.push_back(mk(1,0,0,0,0,0, 0,  2, O_INIR));
    tab.push_back(mk(1,0,0,0,0,0, 0,  3, O_NONE));
    tab.push_back(mk(1,0,0,1,0,0, 1,  4, O_REG));
    tab.push_back(mk(1,0,0,0,1,0, 1,  5, O_NONE));
    tab.push_back(mk(1,0,0,0,1,0, 1,  6, O_PJ));
    tab.push_back(mk(1,0,0,0,0,0, 1,  3, O_NONE));
    tab.push_back(mk(1,0,0,1,0,0, 7,  4, O_REG));
    tab.push_back(mk(1,0,0,0,1,1, 7,  5, O_NONE));
    tab.push_back(mk(1,0,0,0,1,1, 7,  8, O_ACE));
    tab.push_back(mk(1,0,0,0,0,0, 7,  8, O_ACE));
    tab.push_back(mk(1,0,0,1,0,0, 7,  8, O_ACE));
    tab.push_back(mk(1,1,1,0,0,0, 0,  1, O_PREP));
    tab.push_back(mk(1,0,1,0,0,0, 0,  2, O_INIR));
    tab.push_back(mk(1,0,0,0,0,0, 0,  3, O_NONE));
    tab.push_back(mk(1,0,0,1,0,0, 7,  4, O_REG));
    tab.push_back(mk(1,0,0,0,1,1, 7,  5, O_NONE));
    tab.push_back(mk(1,0,0,0,1,1, 7,  7, O_PR));
    tab.push_back(mk(1,0,0,0,0,0, 8,  2, O_INIR));
    tab.push_back(mk(1,0,0,0,0,0, 8,  3, O_NONE));
    tab.push_back(mk(1,0,0,1,0,0, 15, 4, O_REG));
    tab.push_back(mk(1,0,0,0,1,1, 15, 5, O_NONE));
    tab.push_back(mk(1,0,0,0,1,1, 15, 8, O_ACE));
    tab.push_back(mk(1,1,0,0,0,0, 0,  1, O_PREP));
    tab.push_back(mk(1,0,0,0,0,0, 0,  2, O_INIR));
    tab.push_back(mk(1,0,0,0,0,0, 0,  3, O_NONE));
    tab.push_back(mk(1,0,0,1,0,0, 0,  4, O_REG));
    tab.push_back(mk(1,0,0,0,0,1, 0,  5, O_NONE));
    tab.push_back(mk(1,0,0,0,0,1, 0,  9, O_ERR));
    tab.push_back(mk(1,0,0,0,0,0, 0,  9, O_ERR));
    tab.push_back(mk(1,1,0,0,0,0, 0,  1, O_PREP));
    tab.push_back(mk(1,0,0,0,0,0, 0,  2, O_INIR));
    tab.push_back(mk(1,0,0,0,0,0, 0,  3, O_NONE));
    tab.push_back(mk(1,0,0,1,0,0, 0,  4, O_REG));
    tab.push_back(mk(1,0,0,0,1,0, 0,  5, O_NONE));
    tab.push_back(mk(1,0,0,0,1,0, 0,  6, O_PJ));
    tab.push_back(mk(0,0,0,0,0,0, 0,  0, O_NONE));
    tab.push_back(mk(1,1,0,0,0,0, 0,  1, O_PREP));
    tab.push_back(mk(1,1,0,0,0,0, 0,  2, O_INIR));
    tab.push_back(mk(1,1,0,0,0,0, 0,  3, O_NONE));
    tab.push_back(mk(1,1,0,0,0,0, 0,  3, O_NONE));
    tab.push_back(mk(1,0,0,1,0,0, 7,  4, O_REG));
    tab.push_back(mk(1,0,0,0,1,1, 7,  5, O_NONE));
    tab.push_back(mk(1,0,0,0,1,1, 7,  8, O_ACE));

    drive(0, 0, 0, 0, 0, 0, 4'd0);
    for (int i = 0; i < tab.size(); i++) begin
      drive(tab[i].rst, tab[i].ini, tab[i].sel, tab[i].jf, tab[i].ig, tab[i].fr, tab[i].lim);
      check($sformatf("vec%0d", i), tab[i].est, tab[i].outs);
    end

    drive(1, 1, 0, 0, 0, 0, 4'd0);
    check("tmo_prep", 4'd1, O_PREP);
    drive(1, 0, 0, 0, 0, 0, 4'd0);
    drive(1, 0, 0, 0, 0, 0, 4'd0);
    check("tmo_entra_espera", 4'd3, O_NONE);
    for (int i = 0; i < 2999; i++) drive(1, 0, 0, 0, 0, 0, 4'd0);
    check("tmo_2999", 4'd3, O_NONE);
    drive(1, 0, 0, 0, 0, 0, 4'd0);
`ifdef CONTROLE_JOGO_TIMEOUT_EN
    check("tmo_3000", 4'd10, O_TMO);
`else
    check("tmo_3000", 4'd3, O_NONE);
`endif
    for (int i = 0; i < 100; i++) drive(1, 0, 0, 0, 0, 0, 4'd0);
`ifdef CONTROLE_JOGO_TIMEOUT_EN
    check("tmo_3100", 4'd10, O_TMO);
    drive(1, 0, 0, 1, 0, 0, 4'd0);
    check("tmo_jf_ignorado", 4'd10, O_TMO);
    drive(1, 1, 0, 0, 0, 0, 4'd0);
    check("tmo_reinicia", 4'd1, O_PREP);
`else
    check("tmo_3100", 4'd3, O_NONE);
    drive(1, 0, 0, 1, 0, 0, 4'd0);
    check("sem_tmo_jf", 4'd4, O_REG);
    drive(1, 0, 0, 0, 0, 0, 4'd0);
    drive(1, 0, 0, 0, 0, 0, 4'd0);
    check("sem_tmo_erro", 4'd9, O_ERR);
    drive(1, 1, 0, 0, 0, 0, 4'd0);
    check("sem_tmo_reinicia", 4'd1, O_PREP);
`endif
    drive(1, 0, 0, 0, 0, 0, 4'd0);
    drive(1, 0, 0, 0, 0, 0, 4'd0);
    check("prio_entra_espera", 4'd3, O_NONE);
    for (int i = 0; i < 2999; i++) drive(1, 0, 0, 0, 0, 0, 4'd0);
    drive(1, 0, 0, 1, 0, 0, 4'd0);
    check("prio_jf_terminal", 4'd4, O_REG);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
